// File: rtl/uart_receiver_if.sv
// Byte-side handshake bundle of the UART receiver: received data, valid/ack and error flags.
// The receiver drives everything except rx_ack, which comes from the consumer.
interface uart_receiver_if;
  logic [7:0] RxData;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;

  modport master (
    output RxData,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ack
  );

  modport slave (
    input  RxData,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: deserialises RxD into bytes and presents them on a level-valid/ack handshake.
// Reports framing errors as one-cycle pulses and keeps a sticky overrun flag.
module uart_receiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RxD,
  output logic            busy,
  uart_receiver_if.master rx
);

  localparam int DIV_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = DIV_CNT / 2;
  localparam int TW       = $clog2(DIV_CNT);

  localparam logic [TW-1:0] DIV_LAST  = TW'(DIV_CNT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic          rxd_meta, rxd_s;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_data, rx_data_n;
  logic          valid_r, valid_n;
  logic          frame_err_r, frame_err_n;
  logic          overrun_r, overrun_n;

  // Two-flop synchroniser; idles high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      rx_data     <= rx_data_n;
      valid_r     <= valid_n;
      frame_err_r <= frame_err_n;
      overrun_r   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    rx_data_n   = rx_data;
    valid_n     = valid_r;
    frame_err_n = 1'b0;
    overrun_n   = overrun_r;

    // Ack first so that a byte completing in the same cycle can re-raise valid/overrun.
    if (rx.rx_ack) begin
      if (valid_r) begin
        valid_n = 1'b0;
      end
      overrun_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          timer_n = '0;
        end
      end

      START: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          if (!rxd_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      DATA: begin
        if (timer == DIV_LAST) begin
          timer_n   = '0;
          shift_n   = {rxd_s, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      STOP: begin
        // Leave at mid-stop-bit so a start edge right after the stop bit is not missed.
        if (timer == DIV_LAST) begin
          timer_n = '0;
          state_n = IDLE;
          if (rxd_s) begin
            rx_data_n = shift;
            valid_n   = 1'b1;
            if (valid_r && !rx.rx_ack) begin
              overrun_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign rx.RxData    = rx_data;
  assign rx.rx_valid  = valid_r;
  assign rx.frame_err = frame_err_r;
  assign rx.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: serial frames are driven from a transmitter model and
// received bytes are matched against a queue of expected bytes.
module tb_uart_receiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DIV       = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic RxD   = 1'b1;
  logic busy;

  uart_receiver_if rx_if();

  uart_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .RxD  (RxD),
    .busy (busy),
    .rx   (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  int   fe_count       = 0;
  int   busy_run       = 0;
  int   last_busy_len  = 0;
  int   valid_rise_cyc = 0;
  logic prev_valid     = 1'b0;
  int   start_cyc      = 0;
  int   fe0            = 0;

  logic [7:0] loop_bytes [4] = '{8'h00, 8'hFF, 8'h5A, 8'h80};

  always @(posedge clk) cyc <= cyc + 1;

  // A busy period long enough to be a whole frame that ends without frame_err is a delivered byte.
  always @(negedge clk) begin
    if (rx_if.frame_err === 1'b1) fe_count <= fe_count + 1;
    if (rx_if.rx_valid === 1'b1 && !prev_valid) valid_rise_cyc <= cyc;
    prev_valid <= (rx_if.rx_valid === 1'b1);
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run > 0) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
      if (busy_run >= 100 && rx_if.frame_err === 1'b0) obs_q.push_back(rx_if.RxData);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serialise one 8N1 frame; optionally pulse rx_ack during bit-time slot ack_at.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int ack_at,
                               input bit expect_good);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    if (expect_good) exp_q.push_back(data);
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      RxD = frame[i / DIV];
      rx_if.rx_ack = (i == ack_at);
    end
    @(negedge clk);
    RxD          = 1'b1;
    rx_if.rx_ack = 1'b0;
  endtask

  task automatic checkScoreboard(input string tag);
    int t;
    logic [7:0] o, e;
    while (exp_q.size() > 0) begin
      t = 0;
      while (obs_q.size() == 0 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (obs_q.size() == 0) begin
        checkOutput({tag, " timeout"}, obs_q.size(), 1);
        exp_q.delete();
      end else begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checkOutput(tag, o, e);
      end
    end
    checkOutput({tag, " extra"}, obs_q.size(), 0);
  endtask

  task automatic ackPulse();
    @(negedge clk);
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rx_if.rx_ack = 1'b0;
    tick(5);
    checkOutput("reset RxData", rx_if.RxData, 8'h00);
    checkOutput("reset rx_valid", rx_if.rx_valid, 1'b0);
    checkOutput("reset frame_err", rx_if.frame_err, 1'b0);
    checkOutput("reset overrun", rx_if.overrun, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    reset = 1'b1;
    tick(5);

    $display("[TB] single byte 0xA5");
    fe0 = fe_count;
    applyStimulus(8'hA5, 1'b1, -1, 1'b1);
    tick(2);
    checkScoreboard("a5 byte");
    checkOutput("a5 latency", valid_rise_cyc - start_cyc, 155);
    checkOutput("a5 busy len", last_busy_len, 152);
    checkOutput("a5 rx_valid", rx_if.rx_valid, 1'b1);
    checkOutput("a5 frame_err cnt", fe_count, fe0);
    checkOutput("a5 overrun", rx_if.overrun, 1'b0);
    ackPulse();
    checkOutput("a5 ack clears", rx_if.rx_valid, 1'b0);
    tick(5);

    $display("[TB] start glitch");
    fe0 = fe_count;
    @(negedge clk);
    RxD = 1'b0;
    tick(4);
    RxD = 1'b1;
    tick(30);
    checkOutput("glitch busy len", last_busy_len, 8);
    checkOutput("glitch busy idle", busy, 1'b0);
    checkOutput("glitch rx_valid", rx_if.rx_valid, 1'b0);
    checkOutput("glitch frame_err cnt", fe_count, fe0);
    checkOutput("glitch no byte", obs_q.size(), 0);

    $display("[TB] bad stop bit then good byte");
    fe0 = fe_count;
    applyStimulus(8'h3C, 1'b0, -1, 1'b0);
    tick(30);
    checkOutput("ferr pulse cnt", fe_count, fe0 + 1);
    checkOutput("ferr RxData kept", rx_if.RxData, 8'hA5);
    checkOutput("ferr rx_valid", rx_if.rx_valid, 1'b0);
    applyStimulus(8'h55, 1'b1, -1, 1'b1);
    tick(2);
    checkScoreboard("55 byte");
    checkOutput("55 rx_valid", rx_if.rx_valid, 1'b1);
    ackPulse();
    checkOutput("55 ack clears", rx_if.rx_valid, 1'b0);

    $display("[TB] overrun without ack");
    applyStimulus(8'h11, 1'b1, -1, 1'b1);
    applyStimulus(8'h22, 1'b1, -1, 1'b1);
    tick(2);
    checkScoreboard("ovr bytes");
    checkOutput("ovr RxData", rx_if.RxData, 8'h22);
    checkOutput("ovr rx_valid", rx_if.rx_valid, 1'b1);
    checkOutput("ovr overrun", rx_if.overrun, 1'b1);
    ackPulse();
    checkOutput("ovr ack valid", rx_if.rx_valid, 1'b0);
    checkOutput("ovr ack overrun", rx_if.overrun, 1'b0);

    $display("[TB] ack in stop-sample cycle");
    applyStimulus(8'h11, 1'b1, -1, 1'b1);
    applyStimulus(8'h22, 1'b1, 154, 1'b1);
    tick(2);
    checkScoreboard("same-cycle bytes");
    checkOutput("same-cycle RxData", rx_if.RxData, 8'h22);
    checkOutput("same-cycle rx_valid", rx_if.rx_valid, 1'b1);
    checkOutput("same-cycle overrun", rx_if.overrun, 1'b0);
    ackPulse();
    checkOutput("same-cycle ack", rx_if.rx_valid, 1'b0);

    $display("[TB] break condition");
    fe0 = fe_count;
    @(negedge clk);
    RxD = 1'b0;
    tick(312);
    RxD = 1'b1;
    tick(40);
    checkOutput("break ferr cnt", fe_count, fe0 + 2);
    checkOutput("break rx_valid", rx_if.rx_valid, 1'b0);
    checkOutput("break RxData", rx_if.RxData, 8'h22);
    checkOutput("break no byte", obs_q.size(), 0);

    $display("[TB] reset mid-frame");
    fe0 = fe_count;
    @(negedge clk);
    RxD = 1'b0;
    tick(DIV);
    RxD = 1'b1;
    tick(4 * DIV + 8);
    reset = 1'b0;
    tick(1);
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst RxData", rx_if.RxData, 8'h00);
    checkOutput("midrst rx_valid", rx_if.rx_valid, 1'b0);
    checkOutput("midrst frame_err", rx_if.frame_err, 1'b0);
    checkOutput("midrst overrun", rx_if.overrun, 1'b0);
    tick(3);
    reset = 1'b1;
    tick(20);
    applyStimulus(8'h81, 1'b1, -1, 1'b1);
    tick(2);
    checkScoreboard("81 byte");
    checkOutput("81 RxData", rx_if.RxData, 8'h81);
    checkOutput("81 overrun", rx_if.overrun, 1'b0);
    checkOutput("81 frame_err cnt", fe_count, fe0);
    ackPulse();

    $display("[TB] loopback burst");
    fe0 = fe_count;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(loop_bytes[k], 1'b1, 20, 1'b1);
    end
    tick(2);
    checkScoreboard("loop bytes");
    checkOutput("loop rx_valid", rx_if.rx_valid, 1'b1);
    checkOutput("loop RxData", rx_if.RxData, 8'h80);
    checkOutput("loop overrun", rx_if.overrun, 1'b0);
    checkOutput("loop frame_err cnt", fe_count, fe0);
    ackPulse();
    checkOutput("loop final ack", rx_if.rx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive half of the UART pair: deserialises an asynchronous 8N1 serial line (idle high, start bit 0, 8 data bits LSB first, stop bit 1) into bytes. It sits downstream of the transmitter and shares its CLK_FREQ/BAUD_RATE. Each byte is presented on a level-valid/ack handshake, with framing-error and overrun reporting.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, line bit rate.
(derived) DIV_CNT = CLK_FREQ/BAUD_RATE (434 at defaults); HALF_CNT = DIV_CNT/2 (217); timer width = $clog2(DIV_CNT).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
RxD  input  1  asynchronous serial line.
RxData  output  8  last good received byte; held until the next good byte.
rx_valid  output  1  high while RxData holds an unacknowledged byte.
rx_ack  input  1  consumer acknowledge; clears rx_valid.
frame_err  output  1  one-cycle pulse when the stop bit samples 0.
overrun  output  1  sticky flag: a good byte completed while rx_valid was high with no ack.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at clk edge): both synchroniser flops=1, state=IDLE, timer=0, bit_idx=0, shift=0, RxData=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- RxD passes through a 2-flop synchroniser (rxd_s); the FSM uses only rxd_s.
- IDLE: rxd_s==0 -> START, timer=0.
- START: timer counts 0..HALF_CNT-1. At HALF_CNT-1, rxd_s==0 -> DATA (timer=0, bit_idx=0); rxd_s==1 -> IDLE (glitch rejected, no flags).
- DATA: timer counts 0..DIV_CNT-1. At DIV_CNT-1, sample rxd_s: shift = {rxd_s, shift[7:1]}, bit_idx+1, timer=0. After the 8th sample (bit_idx==7) -> STOP.
- STOP: at timer==DIV_CNT-1, sample rxd_s, then -> IDLE.
  - Sample 1: RxData<=shift, rx_valid<=1.
  - Sample 0: frame_err pulses for 1 cycle; RxData and rx_valid unchanged.
  - The FSM returns to IDLE at mid-stop-bit, so the next start edge is caught without loss.
- Timing: call the edge where IDLE first sees rxd_s==0 "edge 0".
  - Start check at edge HALF_CNT.
  - Data bit k sampled at edge HALF_CNT+(k+1)*DIV_CNT.
  - Stop sampled at edge HALF_CNT+9*DIV_CNT; rx_valid/frame_err are visible after that edge.
- Handshake:
  - rx_ack while rx_valid==1 clears rx_valid next cycle. rx_ack while rx_valid==0 is ignored.
  - Good byte completes with rx_valid==1 and rx_ack==0: RxData is overwritten with the new byte, rx_valid stays 1, overrun<=1.
  - Good byte completes in the same cycle as rx_ack: new byte loaded, rx_valid stays 1, overrun not set.
  - overrun clears on rx_ack, except in a cycle where it is being set (set wins).
- Break (line held low): each ~10-bit period yields a framing error, then a new START. No data is delivered; rx_valid is untouched.
- Reset mid-frame aborts immediately to the reset state. The partial frame is discarded and no flags are produced.
- busy=1 from the cycle after IDLE leaves until the cycle after STOP completes (also for rejected glitches).

Test Plan:
Bench uses CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> DIV_CNT=16, HALF_CNT=8.
- Single byte 0xA5, good stop -> RxData=0xA5, rx_valid rises 8+9*16=152 edges after start detection; frame_err=0, overrun=0; rx_ack clears rx_valid next cycle.
- Start glitch: RxD low for 4 cycles, then high -> FSM back to IDLE after the start check, busy pulse only, rx_valid=0, frame_err=0.
- 0x3C sent with stop bit forced 0 -> one-cycle frame_err pulse, RxData keeps its previous value, rx_valid unchanged; a following 0x55 with good stop is received correctly.
- 0x11 then 0x22 back-to-back, no ack -> RxData=0x22, rx_valid=1, overrun=1. rx_ack then gives rx_valid=0, overrun=0. Repeat with rx_ack exactly in the 0x22 stop-sample cycle -> rx_valid=1, overrun=0.
- Reset driven low at data bit 4 of 0xFF, then released, then 0x81 sent -> all outputs at reset values during reset; afterwards RxData=0x81, no frame_err or overrun.
- Loopback with the transmitter (same parameters), bytes 0x00, 0xFF, 0x5A, 0x80 sent consecutively -> each received in order, one ack per byte, no errors.
